// File: rtl/sound_recorder.sv
// Sample recorder: writes one sample_in word to an external RAM every DIVIDER+1
// clocks while capturing, then reports completion and the number of samples taken.
module sound_recorder #(
  parameter int SAMPLE_W  = 5,
  parameter int ADDR_W    = 12,
  parameter int DIVIDER   = 2084,
  parameter int LAST_ADDR = 2048
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                record,
  input  logic                stop,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     length
);

  localparam int CNT_W = (DIVIDER > 0) ? $clog2(DIVIDER + 1) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIVIDER);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  counter_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              tick;

  // stop beats a coinciding tick, so a stopped take never writes on its last cycle
  assign tick = (state_reg == S_CAPTURE) && (counter_reg == CNT_LAST) && !stop;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      counter_reg <= '0;
      addr_reg    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      length      <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (record) begin
            state_reg   <= S_CAPTURE;
            counter_reg <= '0;
            addr_reg    <= '0;
            busy        <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (stop) begin
            state_reg <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            length    <= {1'b0, addr_reg};
          end else begin
            counter_reg <= (counter_reg == CNT_LAST) ? '0 : counter_reg + 1'b1;
            if (tick) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_reg;
              wr_data <= sample_in;
              // the final write and the end of the take share one edge
              if (addr_reg == ADDR_LAST) begin
                state_reg <= S_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                length    <= {1'b0, addr_reg} + 1'b1;
              end else begin
                addr_reg <= addr_reg + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_recorder.sv
// Bench for sound_recorder: a small-parameter instance driven through directed and
// random takes, plus a default-parameter instance checked over its first writes.
module tb_sound_recorder;

  localparam int SW    = 5;
  localparam int AW    = 4;
  localparam int DIV   = 3;
  localparam int LAST  = 7;
  localparam int P     = DIV + 1;
  localparam int N     = LAST + 1;
  localparam int D_AW  = 12;
  localparam int D_P   = 2085;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, record, stop;
  logic [SW-1:0] sample_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_data;
  logic          busy, done;
  logic [AW:0]   length;

  logic            record2, stop2;
  logic [SW-1:0]   sample2;
  logic            wr_en2;
  logic [D_AW-1:0] wr_addr2;
  logic [SW-1:0]   wr_data2;
  logic            busy2, done2;
  logic [D_AW:0]   length2;

  sound_recorder #(.SAMPLE_W(SW), .ADDR_W(AW), .DIVIDER(DIV), .LAST_ADDR(LAST)) dut (
    .CLOCK_50(clk), .reset(reset), .record(record), .stop(stop), .sample_in(sample_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .length(length)
  );

  sound_recorder dut_def (
    .CLOCK_50(clk), .reset(reset), .record(record2), .stop(stop2), .sample_in(sample2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .busy(busy2), .done(done2),
    .length(length2)
  );

  // external RAM written by the recorder
  logic [SW-1:0] ram [16];
  always @(posedge clk) if (wr_en) ram[wr_addr] <= wr_data;

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            len_m = 0;
  logic [AW-1:0] addr_m = '0;
  logic [SW-1:0] data_m = '0;
  logic [SW-1:0] ram_m [16];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit ew, input bit eb, input bit ed);
    chk("wr_en", wr_en, ew);
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("length", length, len_m);
    chk("wr_addr", wr_addr, addr_m);
    chk("wr_data", wr_data, data_m);
  endtask

  task automatic check_ram(input int n);
    for (int i = 0; i < n; i++) chk($sformatf("ram[%0d]", i), ram[i], ram_m[i]);
  endtask

  // One take. Offsets count edges after the starting edge s; 0 disables the feature.
  task automatic run_take(input int stop_off, input int rst_off, input int rec_off,
                          input bit both, input bit keep);
    int s, d, writes, re, e;
    bit full, alive, ew;
    record = 1'b1;
    stop = both;
    sample_in = SW'($urandom);
    step();
    s = cyc;
    d = s + P * N;
    full = 1'b1;
    if (stop_off > 0 && stop_off <= P * N) begin
      d = s + stop_off;
      full = 1'b0;
    end
    writes = full ? N : (d - s - 1) / P;
    re = (rst_off > 0) ? s + rst_off : 0;
    while (1) begin
      e = cyc;
      alive = (re == 0) || (e < re);
      ew = alive && (e > s) && ((e - s) % P == 0) && ((e < d) || (e == d && full));
      if (ew) begin
        addr_m = AW'((e - s) / P - 1);
        data_m = sample_in;
        ram_m[addr_m] = sample_in;
      end
      if (alive && e == d) len_m = writes;
      if (!alive) begin
        len_m = 0;
        addr_m = '0;
        data_m = '0;
      end
      check_outputs(ew, alive && e >= s && e < d, alive && e == d);
      if ((re == 0 && e == d + 1) || (re != 0 && e == re + 2)) break;
      record = (rec_off > 0 && e + 1 == s + rec_off) || (keep && (e + 1 == d || e + 1 == d + 1));
      stop = (stop_off > 0 && e + 1 == s + stop_off);
      reset = (re != 0 && e + 1 == re);
      sample_in = SW'($urandom);
      step();
    end
    if (!keep) record = 1'b0;
    stop = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int  s;
    bit  ew;
    for (int i = 0; i < 16; i++) ram_m[i] = '0;
    reset = 1'b1; record = 1'b0; stop = 1'b0; sample_in = '0;
    record2 = 1'b0; stop2 = 1'b0; sample2 = '0;
    step();
    step();
    check_outputs(1'b0, 1'b0, 1'b0);
    chk("def_length_rst", length2, 0);
    chk("def_busy_rst", busy2, 0);
    reset = 1'b0;

    // stop alone in IDLE does nothing
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outputs(1'b0, 1'b0, 1'b0);
    end
    stop = 1'b0;

    run_take(0, 0, 0, 1'b0, 1'b0);          // full take
    check_ram(N);
    run_take(13, 0, 0, 1'b0, 1'b0);         // stop one clock after 3rd write
    run_take(20, 0, 0, 1'b0, 1'b0);         // stop on 5th tick
    run_take(1, 0, 0, 1'b0, 1'b0);          // stop in first capture cycle
    run_take(P * N, 0, 0, 1'b0, 1'b0);      // stop on the final tick
    run_take(0, 0, 9, 1'b0, 1'b1);          // record mid-take, held through DONE
    run_take(0, 0, 0, 1'b0, 1'b0);          // restarted take from addr 0
    run_take(0, 0, 0, 1'b1, 1'b0);          // record and stop together in IDLE
    run_take(0, 9, 0, 1'b0, 1'b0);          // reset after 2nd write
    run_take(0, 0, 0, 1'b0, 1'b0);
    check_ram(N);

    for (int t = 0; t < 8; t++)
      run_take($urandom_range(1, P * N + 4), 0, $urandom_range(1, P * N - 1),
               1'($urandom), 1'b0);

    // default parameters: first three writes, then stop
    record2 = 1'b1;
    sample2 = SW'($urandom);
    step();
    s = cyc;
    record2 = 1'b0;
    chk("def_busy", busy2, 1);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < D_P; j++) begin
        sample2 = SW'($urandom);
        step();
        ew = ((cyc - s) % D_P) == 0;
        chk("def_wr_en", wr_en2, ew);
        if (ew) begin
          chk("def_wr_addr", wr_addr2, k);
          chk("def_wr_data", wr_data2, sample2);
        end
      end
    end
    stop2 = 1'b1;
    step();
    stop2 = 1'b0;
    chk("def_done", done2, 1);
    chk("def_length", length2, 3);
    chk("def_busy_end", busy2, 0);
    chk("def_wr_en_stop", wr_en2, 0);
    step();
    chk("def_done_pulse", done2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
